// File: rtl/seg_scan_pkg.sv
// Shared types and width limits for the seven-segment scan controller.
package seg_scan_pkg;

  localparam int MAX_DIGITS   = 8;
  localparam int MAX_PRESCALE = 65536;
  localparam int IDX_W        = $clog2(MAX_DIGITS);
  localparam int CNT_W        = $clog2(MAX_PRESCALE);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_scan_if.sv
// Display-value load handshake plus decoder/digit-driver outputs of the scan controller.
// master = value producer side, slave = scan controller side.
interface seg_scan_if #(
  parameter int DIGITS = 4
);

  logic                  load;
  logic [4*DIGITS-1:0]   load_data;
  logic                  load_mode;
  logic                  ready;
  logic [3:0]            data;
  logic                  mode;
  logic [DIGITS-1:0]     dig_en;
  logic                  frame_done;

  modport master (
    output load, load_data, load_mode,
    input  ready, data, mode, dig_en, frame_done
  );

  modport slave (
    input  load, load_data, load_mode,
    output ready, data, mode, dig_en, frame_done
  );

endinterface

// File: rtl/seg_scan_prescaler.sv
// Free-running slot counter 0..PRESCALE-1 with start, blank-end and slot-end strobes.
// Strobes are combinational from the count; no backpressure, counts every cycle.
module seg_scan_prescaler
  import seg_scan_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_start,
  output logic blank_end,
  output logic slot_end
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign slot_start = (cnt == '0);
  assign blank_end  = (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end   = (cnt == CNT_W'(PRESCALE - 1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler sharing one 7-seg decoder across DIGITS positions; SEG_SCAN_LZB_EN adds leading-zero blanking.
// New values take effect at the next frame boundary; READY stays low while one is pending and extra LOADs are dropped.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [4*DIGITS-1:0] pend_data, disp_data;
  logic                pend_mode, disp_mode, pend_valid;
  logic [3:0]          data_q, cur_nib;
  logic                mode_q, frame_done_q;
  logic                slot_start, blank_end, slot_end, boundary;
  logic [DIGITS-1:0]   show_mask, dig_en_c;

  seg_scan_prescaler #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_start (slot_start),
    .blank_end  (blank_end),
    .slot_end   (slot_end)
  );

  assign boundary = (state_q == ST_SHOW) && slot_end && (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    cur_nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_nib = disp_data[4*i +: 4];
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic lead;
  // Walk down from the top digit; digit 0 is never blanked.
  always_comb begin
    show_mask = '1;
    lead      = !disp_mode;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead = lead && (disp_data[4*i +: 4] == 4'h0);
      if (lead) show_mask[i] = 1'b0;
    end
  end
`else
  assign show_mask = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BLANK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dig_en_c = '0;
    case (state_q)
      ST_BLANK: begin
        if (blank_end) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) dig_en_c[i] = show_mask[i];
        end
        if (slot_end) state_d = ST_BLANK;
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      data_q       <= '0;
      mode_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pend_data    <= '0;
      pend_mode    <= 1'b0;
      pend_valid   <= 1'b0;
      disp_data    <= '0;
      disp_mode    <= 1'b0;
    end else begin
      frame_done_q <= boundary;
      if ((state_q == ST_SHOW) && slot_end) begin
        idx_q <= boundary ? '0 : idx_q + IDX_W'(1);
      end
      // Sample the digit while enables are off so DATA never moves under a lit digit.
      if ((state_q == ST_BLANK) && slot_start) begin
        data_q <= cur_nib;
        mode_q <= disp_mode;
      end
      if (bus.load && !pend_valid) begin
        pend_data  <= bus.load_data;
        pend_mode  <= bus.load_mode;
        pend_valid <= 1'b1;
      end else if (boundary && pend_valid) begin
        disp_data  <= pend_data;
        disp_mode  <= pend_mode;
        pend_valid <= 1'b0;
      end
    end
  end

  assign bus.ready      = !pend_valid;
  assign bus.data       = data_q;
  assign bus.mode       = mode_q;
  assign bus.dig_en     = dig_en_c;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
// Expected per-frame values are a hand-written table indexed by cycle/32.
module tb_seg_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = DIGITS * PRESCALE;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] fr_val  [7];
  logic        fr_mode [7];
  logic [3:0]  fr_mask [7];

  seg_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS       (DIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_cycle(input int c, input int f);
    int          pos;
    int          slot;
    logic [3:0]  exp_en;
    logic [15:0] v;
    pos    = c % PRESCALE;
    slot   = (c / PRESCALE) % DIGITS;
    exp_en = (pos >= BLANK) ? (4'(1 << slot) & fr_mask[f]) : 4'b0000;
    chk($sformatf("dig_en c%0d", c), 32'(bus.dig_en), 32'(exp_en));
    chk($sformatf("frame_done c%0d", c), 32'(bus.frame_done), 32'((c > 0) && (c % FRAME == 0)));
    if (pos >= BLANK) begin
      v = fr_val[f];
      chk($sformatf("data c%0d", c), 32'(bus.data), 32'(v[4*slot +: 4]));
      chk($sformatf("mode c%0d", c), 32'(bus.mode), 32'(fr_mode[f]));
    end
  endtask

  task automatic drive_load(input logic [15:0] d, input logic m);
    bus.load      = 1'b1;
    bus.load_data = d;
    bus.load_mode = m;
  endtask

  initial begin
    fr_val[0] = 16'h0000; fr_mode[0] = 1'b0;
    fr_val[1] = 16'h1A3F; fr_mode[1] = 1'b0;
    fr_val[2] = 16'hBEEF; fr_mode[2] = 1'b1;
    fr_val[3] = 16'h0005; fr_mode[3] = 1'b0;
    fr_val[4] = 16'h0005; fr_mode[4] = 1'b1;
    fr_val[5] = 16'h0C05; fr_mode[5] = 1'b0;
    fr_val[6] = 16'h0000; fr_mode[6] = 1'b0;
`ifdef SEG_SCAN_LZB_EN
    fr_mask[0] = 4'b0001; fr_mask[1] = 4'b1111; fr_mask[2] = 4'b1111;
    fr_mask[3] = 4'b0001; fr_mask[4] = 4'b1111; fr_mask[5] = 4'b0111;
    fr_mask[6] = 4'b0001;
`else
    for (int i = 0; i < 7; i++) fr_mask[i] = 4'b1111;
`endif

    bus.load      = 1'b0;
    bus.load_data = '0;
    bus.load_mode = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst dig_en", 32'(bus.dig_en), 32'h0);
    chk("rst data", 32'(bus.data), 32'h0);
    chk("rst mode", 32'(bus.mode), 32'h0);
    chk("rst frame_done", 32'(bus.frame_done), 32'h0);
    chk("rst ready", 32'(bus.ready), 32'h1);

    rst_n = 1'b1;
    for (int c = 0; c < 180; c++) begin
      check_cycle(c, c / FRAME);
      bus.load = 1'b0;
      case (c)
        3:   begin chk("ready before load1", 32'(bus.ready), 32'h1); drive_load(16'h1A3F, 1'b0); end
        4:   chk("ready after load1", 32'(bus.ready), 32'h0);
        10:  begin chk("ready at dropped load", 32'(bus.ready), 32'h0); drive_load(16'h2222, 1'b0); end
        31:  chk("ready at boundary", 32'(bus.ready), 32'h0);
        32:  chk("ready after boundary", 32'(bus.ready), 32'h1);
        40:  drive_load(16'hBEEF, 1'b1);
        41:  chk("ready after load3", 32'(bus.ready), 32'h0);
        64:  chk("ready after boundary2", 32'(bus.ready), 32'h1);
        70:  drive_load(16'h0005, 1'b0);
        100: drive_load(16'h0005, 1'b1);
        130: drive_load(16'h0C05, 1'b0);
        165: drive_load(16'h4321, 1'b0);
        179: chk("ready before reset", 32'(bus.ready), 32'h0);
        default: ;
      endcase
      @(negedge clk);
    end

    // Cycle 180 is mid-SHOW of digit 2 in frame 5.
    check_cycle(180, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst dig_en", 32'(bus.dig_en), 32'h0);
    chk("midrst data", 32'(bus.data), 32'h0);
    chk("midrst mode", 32'(bus.mode), 32'h0);
    chk("midrst ready", 32'(bus.ready), 32'h1);
    chk("midrst frame_done", 32'(bus.frame_done), 32'h0);
    repeat (2) @(negedge clk);
    chk("held rst dig_en", 32'(bus.dig_en), 32'h0);

    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      check_cycle(c, 6);
      if (c == 0) chk("ready after reset", 32'(bus.ready), 32'h1);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scheduler that shares one binary-to-7-segment decoder among `DIGITS` common-anode digit positions. It holds a frame-coherent copy of the multi-digit value and presents one nibble plus `MODE` to the decoder at a time. It drives a one-hot digit enable with blanking gaps between digits to suppress ghosting. It sits between the datapath that produces display values and the decoder/pin drivers.

## Interface
- `DIGITS`, 4: number of digit positions; 2..8.
- `PRESCALE`, 50000: clock cycles per digit slot; must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 4: cycles at the start of each slot with all enables off; ≥ 1.
- `CLK` in 1: single clock; all logic rising-edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `LOAD` in 1: single-cycle request to accept a new display value; honoured only while `READY`=1.
- `LOAD_DATA` in 4*DIGITS: nibble i (bits 4i+3:4i) is digit i; digit 0 is least significant.
- `LOAD_MODE` in 1: 0 = unsigned hex, 1 = signed; forwarded to the decoder.
- `READY` out 1: 1 = pending buffer empty, `LOAD` will be captured.
- `DATA` out 4: nibble to the decoder, registered.
- `MODE` out 1: mode to the decoder, registered.
- `DIG_EN` out DIGITS: one-hot active-high digit enable; all-zero while blanking.
- `FRAME_DONE` out 1: one-cycle pulse at the end of each complete frame.

## Operation
- Registers: `pend_data`/`pend_mode` (pending), `disp_data`/`disp_mode` (displayed), `pend_valid`, digit index `idx`, slot counter `cnt`, state.
- States:
  - BLANK: `cnt` 0..BLANK_CYCLES-1. `DIG_EN`=0. `DATA`/`MODE` load digit `idx` of `disp_*` on the first BLANK cycle.
  - SHOW: `cnt` BLANK_CYCLES..PRESCALE-1. `DIG_EN`=1<<idx. `DATA`/`MODE` are held.
- Transitions:
  - BLANK→SHOW when `cnt`=BLANK_CYCLES-1.
  - SHOW→BLANK when `cnt`=PRESCALE-1. `cnt` clears, and `idx` increments, wrapping DIGITS-1→0.
- Frame boundary is the last SHOW cycle of `idx`=DIGITS-1. On that cycle:
  - `FRAME_DONE`=1 on the next cycle, for one cycle.
  - If `pend_valid`: `disp_*`←`pend_*` and `pend_valid`←0.
- `READY` = !`pend_valid`.
- `LOAD` with `READY`=1: capture into `pend_*` and set `pend_valid`.
- `LOAD` with `READY`=0: dropped silently; `pend_*` is unchanged.
- `LOAD` on the boundary cycle while `READY`=1: captured into pending. It is displayed from the following frame boundary; there is no bypass.
- Displayed value never changes mid-frame (no tearing).

## Timing
- Reset values:
  - State BLANK, `idx`=0, `cnt`=0.
  - `DIG_EN`=0, `DATA`=0, `MODE`=0, `FRAME_DONE`=0, `READY`=1.
  - `disp_*`=0, `pend_valid`=0.
- Reset mid-frame forces these values immediately (asynchronous). The first edge after release starts BLANK for digit 0.
- Slot length is PRESCALE cycles; frame length is DIGITS×PRESCALE cycles.
- `DIG_EN` is high for PRESCALE−BLANK_CYCLES cycles per slot.
- `DATA` changes only while `DIG_EN`=0.
- `LOAD` to visible: `READY` falls the cycle after capture. The new value appears in the first slot after the next frame boundary, so the latency is ≤ DIGITS×PRESCALE+1 cycles.
- `READY` returns to 1 the cycle after the boundary transfer.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - While `disp_mode`=0, zero nibbles from digit DIGITS-1 downward, up to the first nonzero nibble, keep `DIG_EN`=0 during their SHOW phase.
  - Digit 0 is always shown.
  - Slot timing and `FRAME_DONE` are unchanged.
- `SEG_SCAN_LZB_EN` undefined: every digit is enabled during SHOW. No blanking logic is present.

## Structure
- Package `seg_scan_pkg`:
  - State encoding constants `ST_BLANK`, `ST_SHOW`.
  - Width limits `MAX_DIGITS`=8 and the `clog2`-based widths for `idx` and `cnt`.
- One sub-module, `seg_scan_prescaler`:
  - Free-running 0..PRESCALE-1 counter.
  - Outputs a `blank_end` strobe at count BLANK_CYCLES-1 and a `slot_end` strobe at count PRESCALE-1.
- The top level holds the FSM, the index, the buffers and the enable decode.

## Test plan
All scenarios use DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.

- Reset release, no LOAD → `DIG_EN` cycles 0001,0010,0100,1000. Each enable is high 6 cycles with 2 zero cycles before it, and `DATA`=0 throughout.
- `LOAD_DATA`=16'h1A3F, `LOAD_MODE`=0 at cycle 3:
  - The first frame still shows 0.
  - The next frame shows `DATA` F,3,A,1 for `DIG_EN` 0001,0010,0100,1000 respectively.
- Second `LOAD` of 16'h2222 while `READY`=0 → dropped; 16'h1A3F is displayed. After a third `LOAD` with `READY`=1, that value appears one boundary later.
- Period check → `FRAME_DONE` pulses exactly every 32 cycles, each pulse 1 cycle wide.
- Assert `RST_N`=0 mid-SHOW of digit 2 → `DIG_EN`=0, `DATA`=0 and `READY`=1 immediately; digit 0 restarts after release.
- With `SEG_SCAN_LZB_EN` defined, `LOAD` 16'h0005 mode 0 → only `DIG_EN`[0] ever asserts. With mode 1, or without the macro, all four digits assert.
